// File: rtl/aos_softreg_router.sv
// SoftReg virtualiser: routes host requests to NUM_APPS app slots and arbitrates responses back.
// Optional read timeout compiled in with `define AOS_SOFTREG_TIMEOUT_EN.
module aos_softreg_router #(
    parameter int unsigned NUM_APPS       = 4,
    parameter int unsigned SEL_LSB        = 3,
    parameter int unsigned SEL_BITS       = 8,
    parameter int unsigned RESP_LOG_DEPTH = 3,
    parameter int unsigned TIMEOUT_CYCLES = 4096,
    parameter logic [63:0] ERR_DATA       = 64'hDEAD_BEEF_DEAD_BEEF
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NUM_APPS-1:0]     app_enable,
    input  logic                    softreg_req_valid,
    input  logic                    softreg_req_iswrite,
    input  logic [31:0]             softreg_req_addr,
    input  logic [63:0]             softreg_req_data,
    output logic                    softreg_resp_valid,
    output logic [63:0]             softreg_resp_data,
    output logic [NUM_APPS-1:0]     app_softreg_req_valid,
    output logic [NUM_APPS-1:0]     app_softreg_req_iswrite,
    output logic [NUM_APPS*32-1:0]  app_softreg_req_addr,
    output logic [NUM_APPS*64-1:0]  app_softreg_req_data,
    input  logic [NUM_APPS-1:0]     app_softreg_resp_valid,
    input  logic [NUM_APPS*64-1:0]  app_softreg_resp_data,
    output logic [15:0]             resp_drop_cnt
);
    localparam int unsigned DEPTH = 1 << RESP_LOG_DEPTH;
    localparam int unsigned NQ    = NUM_APPS + 1;
    localparam int unsigned PW    = (NQ > 1) ? $clog2(NQ) : 1;
    localparam int unsigned CW    = RESP_LOG_DEPTH + 1;
    localparam logic [63:0] LO_MASK = (64'd1 << SEL_LSB) - 64'd1;

    logic [SEL_BITS-1:0]       sel;
    logic [63:0]               addr_w;
    logic [31:0]               fwd_addr;
    logic [NUM_APPS-1:0]       fwd, fwd_rd, enq, tmo;
    logic                      err_read;
    logic [NQ-1:0]             push, pop;
    logic [63:0]               push_data [NQ];
    logic [63:0]               mem_q [NQ][DEPTH];
    logic [RESP_LOG_DEPTH-1:0] wr_q [NQ];
    logic [RESP_LOG_DEPTH-1:0] rd_q [NQ];
    logic [CW-1:0]             count_q [NQ];
    logic [CW-1:0]             count_d [NQ];
    logic [CW-1:0]             credit_q [NUM_APPS];
    logic [CW-1:0]             credit_d [NUM_APPS];
    logic [CW-1:0]             out_q [NUM_APPS];
    logic [CW-1:0]             out_d [NUM_APPS];
    logic [PW-1:0]             ptr_q, ptr_d, gnt_idx;
    logic                      gnt_any;
    logic                      gnt_valid_q, resp_valid_q;
    logic [63:0]               gnt_data_q, resp_data_q;
    logic [NUM_APPS-1:0]       req_valid_q, req_iswrite_q;
    logic [NUM_APPS*32-1:0]    req_addr_q;
    logic [NUM_APPS*64-1:0]    req_data_q;
    logic [15:0]               drop_q, drop_d;
    logic [16:0]               drop_inc, drop_sum;
`ifdef AOS_SOFTREG_TIMEOUT_EN
    localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);
    logic [TW-1:0]             timer_q [NUM_APPS];
    logic [TW-1:0]             timer_d [NUM_APPS];
`endif

    // Strip the select field: keep bits below it, pull bits above it down.
    assign sel      = softreg_req_addr[SEL_LSB +: SEL_BITS];
    assign addr_w   = {32'b0, softreg_req_addr};
    assign fwd_addr = 32'((addr_w & LO_MASK) | ((addr_w >> (SEL_LSB + SEL_BITS)) << SEL_LSB));

    always_comb begin
        fwd = '0;
        for (int unsigned i = 0; i < NUM_APPS; i++) begin
            if (softreg_req_valid && app_enable[i] && (32'(sel) == i) &&
                (softreg_req_iswrite || credit_q[i] != '0))
                fwd[i] = 1'b1;
        end
        fwd_rd   = fwd & {NUM_APPS{!softreg_req_iswrite}};
        err_read = softreg_req_valid && !softreg_req_iswrite && (fwd == '0);
    end

    always_comb begin
        int unsigned idx;
        idx     = 0;
        gnt_any = 1'b0;
        gnt_idx = '0;
        pop     = '0;
        for (int unsigned k = 0; k < NQ; k++) begin
            idx = (32'(ptr_q) + k) % NQ;
            if (!gnt_any && count_q[PW'(idx)] != '0) begin
                gnt_any = 1'b1;
                gnt_idx = PW'(idx);
            end
        end
        if (gnt_any) pop[gnt_idx] = 1'b1;
        ptr_d = gnt_any ? PW'((32'(gnt_idx) + 1) % NQ) : ptr_q;
    end

    always_comb begin
        enq      = '0;
        tmo      = '0;
        push     = '0;
        drop_inc = '0;
        for (int unsigned i = 0; i < NUM_APPS; i++) begin
            enq[i] = app_softreg_resp_valid[i] && app_enable[i] && (out_q[i] != '0);
`ifdef AOS_SOFTREG_TIMEOUT_EN
            tmo[i] = (out_q[i] != '0) && (timer_q[i] == TW'(TIMEOUT_CYCLES - 1)) && !enq[i];
            timer_d[i] = (enq[i] || tmo[i] || out_q[i] == '0) ? '0 : timer_q[i] + TW'(1);
`endif
            push[i]      = enq[i] | tmo[i];
            push_data[i] = enq[i] ? app_softreg_resp_data[i*64 +: 64] : ERR_DATA;
            if (app_softreg_resp_valid[i] && !enq[i]) drop_inc = drop_inc + 17'd1;
            count_d[i]  = count_q[i] + CW'(push[i]) - CW'(pop[i]);
            out_d[i]    = out_q[i] + CW'(fwd_rd[i]) - CW'(push[i]);
            credit_d[i] = credit_q[i] - CW'(fwd_rd[i]) + CW'(pop[i]);
`ifndef AOS_SOFTREG_TIMEOUT_EN
            // A disabled app forgets its outstanding reads; credit = free slots.
            if (!app_enable[i]) begin
                out_d[i]    = '0;
                credit_d[i] = CW'(DEPTH) - count_d[i];
            end
`endif
        end
        push[NUM_APPS]      = err_read && (count_q[NUM_APPS] != CW'(DEPTH));
        push_data[NUM_APPS] = ERR_DATA;
        if (err_read && !push[NUM_APPS]) drop_inc = drop_inc + 17'd1;
        count_d[NUM_APPS]   = count_q[NUM_APPS] + CW'(push[NUM_APPS]) - CW'(pop[NUM_APPS]);
        drop_sum = {1'b0, drop_q} + drop_inc;
        drop_d   = drop_sum[16] ? 16'hFFFF : drop_sum[15:0];
    end

    always_ff @(posedge clk) begin
        for (int unsigned i = 0; i < NQ; i++)
            if (push[i]) mem_q[i][wr_q[i]] <= push_data[i];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned i = 0; i < NQ; i++) begin
                wr_q[i]    <= '0;
                rd_q[i]    <= '0;
                count_q[i] <= '0;
            end
            for (int unsigned i = 0; i < NUM_APPS; i++) begin
                credit_q[i] <= CW'(DEPTH);
                out_q[i]    <= '0;
`ifdef AOS_SOFTREG_TIMEOUT_EN
                timer_q[i]  <= '0;
`endif
            end
            ptr_q         <= '0;
            gnt_valid_q   <= 1'b0;
            gnt_data_q    <= '0;
            resp_valid_q  <= 1'b0;
            resp_data_q   <= '0;
            req_valid_q   <= '0;
            req_iswrite_q <= '0;
            req_addr_q    <= '0;
            req_data_q    <= '0;
            drop_q        <= '0;
        end else begin
            for (int unsigned i = 0; i < NQ; i++) begin
                wr_q[i]    <= wr_q[i] + RESP_LOG_DEPTH'(push[i]);
                rd_q[i]    <= rd_q[i] + RESP_LOG_DEPTH'(pop[i]);
                count_q[i] <= count_d[i];
            end
            for (int unsigned i = 0; i < NUM_APPS; i++) begin
                credit_q[i] <= credit_d[i];
                out_q[i]    <= out_d[i];
`ifdef AOS_SOFTREG_TIMEOUT_EN
                timer_q[i]  <= timer_d[i];
`endif
                req_valid_q[i]        <= fwd[i];
                req_iswrite_q[i]      <= fwd[i] && softreg_req_iswrite;
                req_addr_q[i*32 +: 32] <= fwd[i] ? fwd_addr : '0;
                req_data_q[i*64 +: 64] <= fwd[i] ? softreg_req_data : '0;
            end
            ptr_q        <= ptr_d;
            gnt_valid_q  <= gnt_any;
            gnt_data_q   <= gnt_any ? mem_q[gnt_idx][rd_q[gnt_idx]] : '0;
            resp_valid_q <= gnt_valid_q;
            resp_data_q  <= gnt_valid_q ? gnt_data_q : '0;
            drop_q       <= drop_d;
        end
    end

    assign softreg_resp_valid      = resp_valid_q;
    assign softreg_resp_data       = resp_data_q;
    assign app_softreg_req_valid   = req_valid_q;
    assign app_softreg_req_iswrite = req_iswrite_q;
    assign app_softreg_req_addr    = req_addr_q;
    assign app_softreg_req_data    = req_data_q;
    assign resp_drop_cnt           = drop_q;
endmodule

// File: tb/tb_aos_softreg_router.sv
// Directed self-checking bench for aos_softreg_router (default build, NUM_APPS=4, depth 8).
module tb_aos_softreg_router;
    localparam logic [63:0] ERR = 64'hDEAD_BEEF_DEAD_BEEF;

    logic         clk = 1'b0;
    logic         rst;
    logic [3:0]   app_enable;
    logic         softreg_req_valid, softreg_req_iswrite;
    logic [31:0]  softreg_req_addr;
    logic [63:0]  softreg_req_data;
    logic         softreg_resp_valid;
    logic [63:0]  softreg_resp_data;
    logic [3:0]   app_softreg_req_valid, app_softreg_req_iswrite;
    logic [127:0] app_softreg_req_addr;
    logic [255:0] app_softreg_req_data;
    logic [3:0]   app_softreg_resp_valid;
    logic [255:0] app_softreg_resp_data;
    logic [15:0]  resp_drop_cnt;

    int n_cmp = 0;
    int n_bad = 0;

    aos_softreg_router dut (
        .clk(clk), .rst(rst), .app_enable(app_enable),
        .softreg_req_valid(softreg_req_valid), .softreg_req_iswrite(softreg_req_iswrite),
        .softreg_req_addr(softreg_req_addr), .softreg_req_data(softreg_req_data),
        .softreg_resp_valid(softreg_resp_valid), .softreg_resp_data(softreg_resp_data),
        .app_softreg_req_valid(app_softreg_req_valid), .app_softreg_req_iswrite(app_softreg_req_iswrite),
        .app_softreg_req_addr(app_softreg_req_addr), .app_softreg_req_data(app_softreg_req_data),
        .app_softreg_resp_valid(app_softreg_resp_valid), .app_softreg_resp_data(app_softreg_resp_data),
        .resp_drop_cnt(resp_drop_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        softreg_req_valid      = 1'b0;
        softreg_req_iswrite    = 1'b0;
        softreg_req_addr       = '0;
        softreg_req_data       = '0;
        app_softreg_resp_valid = '0;
        app_softreg_resp_data  = '0;
    endtask

    task automatic do_reset();
        idle_inputs();
        app_enable = 4'b1111;
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic set_req(input logic wr, input logic [31:0] addr, input logic [63:0] data);
        softreg_req_valid   = 1'b1;
        softreg_req_iswrite = wr;
        softreg_req_addr    = addr;
        softreg_req_data    = data;
    endtask

    // Ticks until a response pulse appears (bounded); returns ticks taken and data.
    task automatic wait_resp(output int lat, output logic [63:0] data);
        lat  = -1;
        data = '0;
        for (int c = 1; c <= 20; c++) begin
            tick();
            if (softreg_resp_valid) begin
                lat  = c;
                data = softreg_resp_data;
                break;
            end
        end
    endtask

    task automatic count_resp(input int cycles, output int pulses);
        pulses = 0;
        for (int c = 0; c < cycles; c++) begin
            tick();
            if (softreg_resp_valid) pulses++;
        end
    endtask

    int          lat, pulses, app0_reqs;
    logic [63:0] d;
    logic [63:0] got_d [8];
    int          got_t [8];

    initial begin
        do_reset();
        check("reset_resp_valid", 64'(softreg_resp_valid), 64'd0);
        check("reset_app_valid", 64'(app_softreg_req_valid), 64'd0);
        check("reset_drop_cnt", 64'(resp_drop_cnt), 64'd0);

        // Read to app 2, addr = 2<<3
        set_req(1'b0, 32'd16, '0);
        tick();
        idle_inputs();
        check("rd2_app_valid", 64'(app_softreg_req_valid), 64'h4);
        check("rd2_app_addr", 64'(app_softreg_req_addr[64 +: 32]), 64'd0);
        check("rd2_app_iswrite", 64'(app_softreg_req_iswrite), 64'd0);
        app_softreg_resp_valid[2] = 1'b1;
        app_softreg_resp_data[128 +: 64] = 64'h1234;
        tick();
        idle_inputs();
        wait_resp(lat, d);
        check("rd2_resp_lat", 64'(lat), 64'd2);
        check("rd2_resp_data", d, 64'h1234);

        // Write to app 1 with upper address bits: 0xA80D -> 0xAD
        set_req(1'b1, 32'h0000_A80D, 64'h0123_4567_89AB_CDEF);
        tick();
        idle_inputs();
        check("wr1_app_valid", 64'(app_softreg_req_valid), 64'h2);
        check("wr1_app_iswrite", 64'(app_softreg_req_iswrite), 64'h2);
        check("wr1_app_addr", 64'(app_softreg_req_addr[32 +: 32]), 64'hAD);
        check("wr1_app_data", app_softreg_req_data[64 +: 64], 64'h0123_4567_89AB_CDEF);
        count_resp(5, pulses);
        check("wr1_no_resp", 64'(pulses), 64'd0);

        // Read to missing app 7
        set_req(1'b0, 32'd56, '0);
        tick();
        idle_inputs();
        check("rd7_app_valid", 64'(app_softreg_req_valid), 64'd0);
        wait_resp(lat, d);
        check("rd7_resp_lat", 64'(lat), 64'd2);
        check("rd7_resp_data", d, ERR);

        // Write to missing app 7
        set_req(1'b1, 32'd56, 64'h55);
        tick();
        idle_inputs();
        check("wr7_app_valid", 64'(app_softreg_req_valid), 64'd0);
        count_resp(6, pulses);
        check("wr7_no_resp", 64'(pulses), 64'd0);

        // Read to disabled app 1
        app_enable = 4'b1101;
        set_req(1'b0, 32'd8, '0);
        tick();
        idle_inputs();
        check("rd1dis_app_valid", 64'(app_softreg_req_valid), 64'd0);
        wait_resp(lat, d);
        check("rd1dis_resp_data", d, ERR);
        check("rd1dis_drop_cnt", 64'(resp_drop_cnt), 64'd0);

        // Credit exhaustion on app 0
        do_reset();
        app0_reqs = 0;
        for (int n = 0; n < 9; n++) begin
            set_req(1'b0, 32'd0, '0);
            tick();
            if (app_softreg_req_valid[0]) app0_reqs++;
        end
        idle_inputs();
        pulses = 0;
        d = '0;
        for (int c = 0; c < 8; c++) begin
            tick();
            if (app_softreg_req_valid[0]) app0_reqs++;
            if (softreg_resp_valid) begin
                pulses++;
                d = softreg_resp_data;
            end
        end
        check("cred_app0_reqs", 64'(app0_reqs), 64'd8);
        check("cred_err_pulses", 64'(pulses), 64'd1);
        check("cred_err_data", d, ERR);
        app_softreg_resp_valid[0] = 1'b1;
        app_softreg_resp_data[0 +: 64] = 64'h55;
        tick();
        idle_inputs();
        wait_resp(lat, d);
        check("cred_resp_data", d, 64'h55);
        set_req(1'b0, 32'd0, '0);
        tick();
        idle_inputs();
        check("cred_returned_fwd", 64'(app_softreg_req_valid), 64'h1);

        // Simultaneous responses from all four apps
        do_reset();
        for (int a = 0; a < 4; a++) begin
            set_req(1'b0, 32'(a) << 3, '0);
            tick();
        end
        idle_inputs();
        tick();
        app_softreg_resp_valid = 4'b1111;
        for (int a = 0; a < 4; a++) app_softreg_resp_data[a*64 +: 64] = 64'h100 + 64'(a);
        tick();
        idle_inputs();
        pulses = 0;
        for (int c = 0; c < 12; c++) begin
            tick();
            if (softreg_resp_valid && pulses < 8) begin
                got_d[pulses] = softreg_resp_data;
                got_t[pulses] = c;
                pulses++;
            end
        end
        check("all4_pulses", 64'(pulses), 64'd4);
        for (int k = 0; k < 4; k++) begin
            check($sformatf("all4_data%0d", k), got_d[k], 64'h100 + 64'(k));
            check($sformatf("all4_time%0d", k), 64'(got_t[k] - got_t[0]), 64'(k));
        end

        // Pointer now at 4: error queue wins over app 0 when both arrive together
        set_req(1'b0, 32'd0, '0);
        tick();
        set_req(1'b0, 32'd56, '0);
        app_softreg_resp_valid[0] = 1'b1;
        app_softreg_resp_data[0 +: 64] = 64'h77;
        tick();
        idle_inputs();
        pulses = 0;
        for (int c = 0; c < 10; c++) begin
            tick();
            if (softreg_resp_valid && pulses < 8) begin
                got_d[pulses] = softreg_resp_data;
                pulses++;
            end
        end
        check("ptr4_pulses", 64'(pulses), 64'd2);
        check("ptr4_first", got_d[0], ERR);
        check("ptr4_second", got_d[1], 64'h77);

        // Unsolicited response from app 1
        do_reset();
        app_softreg_resp_valid[1] = 1'b1;
        app_softreg_resp_data[64 +: 64] = 64'h99;
        tick();
        idle_inputs();
        count_resp(6, pulses);
        check("unsol_no_resp", 64'(pulses), 64'd0);
        check("unsol_drop_cnt", 64'(resp_drop_cnt), 64'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
